// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters.
// No logic and no latency; consumed by uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b11,
    STOP  = 2'b10
  } uart_state_t;

  localparam int CLOCKS_PER_PULSE_DEF = 16;
  localparam int DATA_WIDTH_DEF       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop frame, mid-bit sampling, one-cycle valid or framing-error strobe.
// Strobe follows the stop-bit sample by one register; no backpressure, words are dropped if unread.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

  uart_state_t           state, state_nxt;
  logic [CW-1:0]         c_clocks, c_clocks_nxt;
  logic [BW-1:0]         c_bits, c_bits_nxt;
  logic [DATA_WIDTH-1:0] data, data_nxt;
  logic [DATA_WIDTH-1:0] data_out_nxt;
  logic                  data_valid_nxt, frame_err_nxt;
  logic                  rx_s, rx_q, fall;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  // Only an edge starts a frame, so a line stuck low after a framing error stays idle.
  assign fall    = rx_q & ~rx_s;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rx_q       <= 1'b1;
      c_clocks   <= '0;
      c_bits     <= '0;
      data       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_q       <= rx_s;
      c_clocks   <= c_clocks_nxt;
      c_bits     <= c_bits_nxt;
      data       <= data_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    c_clocks_nxt   = c_clocks;
    c_bits_nxt     = c_bits;
    data_nxt       = data;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt    = START;
          c_clocks_nxt = '0;
          c_bits_nxt   = '0;
        end
      end
      START: begin
        if (c_clocks == HALF_LAST) begin
          c_clocks_nxt = '0;
          state_nxt    = rx_s ? IDLE : DATA;
        end else begin
          c_clocks_nxt = c_clocks + 1'b1;
        end
      end
      DATA: begin
        if (c_clocks == BIT_LAST) begin
          c_clocks_nxt = '0;
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (c_bits == BW'(i)) data_nxt[i] = rx_s;
          end
          if (c_bits == DATA_LAST) state_nxt = STOP;
          else                     c_bits_nxt = c_bits + 1'b1;
        end else begin
          c_clocks_nxt = c_clocks + 1'b1;
        end
      end
      STOP: begin
        if (c_clocks == BIT_LAST) begin
          c_clocks_nxt = '0;
          state_nxt    = IDLE;
          if (rx_s) begin
            data_out_nxt   = data;
            data_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt  = 1'b1;
          end
        end else begin
          c_clocks_nxt = c_clocks + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven from a behavioural transmitter, strobes scored against a queue model.
module tb_uart_rx;

  localparam int CPP   = 16;
  localparam int DW    = 8;
  localparam int CPP5  = 5;
  localparam int DW5   = 7;
  // Line change -> 2 sync flops -> edge detect, then half a bit plus (DW+1) bit periods to the stop sample.
  localparam int LAT16 = 3 + CPP / 2 + (DW + 1) * CPP;
  localparam int LAT5  = 3 + CPP5 / 2 + (DW5 + 1) * CPP5;

  typedef struct {
    logic       err;
    logic [7:0] d;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1, rx5 = 1'b1;
  logic [DW-1:0]  dout;
  logic [DW5-1:0] dout5;
  logic dv, fe, busy, dv5, fe5, busy5;

  int cyc = 0;
  int n_checks = 0, n_errors = 0;
  int vld_cnt16 = 0, fe_cnt16 = 0, vld_cnt5 = 0;
  int vld_prev = -1, vld_last = -1;
  exp_t q16[$], q5[$];
  logic [7:0] last16 = 8'h00, last5 = 8'h00;

  uart_rx #(.CLOCKS_PER_PULSE(CPP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .rx(rx),
    .data_out(dout), .data_valid(dv), .frame_err(fe), .rx_busy(busy)
  );

  uart_rx #(.CLOCKS_PER_PULSE(CPP5), .DATA_WIDTH(DW5)) dut5 (
    .clk(clk), .rstn(rstn), .rx(rx5),
    .data_out(dout5), .data_valid(dv5), .frame_err(fe5), .rx_busy(busy5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int line, input logic v);
    if (line == 0) rx = v;
    else           rx5 = v;
  endtask

  task automatic idle(input int line, input int n);
    set_line(line, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input int line, input logic [7:0] d, input logic stop_ok);
    int cpp, dw;
    exp_t e;
    cpp   = (line == 0) ? CPP : CPP5;
    dw    = (line == 0) ? DW : DW5;
    e.err = !stop_ok;
    e.t0  = cyc;
    if (line == 0) begin
      if (stop_ok) last16 = d;
      e.d = last16;
      q16.push_back(e);
    end else begin
      if (stop_ok) last5 = d & 8'h7F;
      e.d = last5;
      q5.push_back(e);
    end
    set_line(line, 1'b0);
    repeat (cpp) @(negedge clk);
    for (int i = 0; i < dw; i++) begin
      set_line(line, d[i]);
      repeat (cpp) @(negedge clk);
    end
    set_line(line, stop_ok);
    repeat (cpp) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rstn && (dv || fe)) begin
      if (dv) begin
        vld_cnt16++;
        vld_prev = vld_last;
        vld_last = cyc;
      end
      if (fe) fe_cnt16++;
      chk("excl16", {31'd0, dv & fe}, 0);
      chk("strobe_expected16", {31'd0, q16.size() != 0}, 1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("kind16", {31'd0, fe}, {31'd0, e.err});
        chk("data16", {24'd0, dout}, {24'd0, e.d});
        chk("lat16", cyc - e.t0, LAT16);
      end
    end
  end

  always @(negedge clk) begin : mon5
    exp_t e;
    if (rstn && (dv5 || fe5)) begin
      if (dv5) vld_cnt5++;
      chk("excl5", {31'd0, dv5 & fe5}, 0);
      chk("strobe_expected5", {31'd0, q5.size() != 0}, 1);
      if (q5.size() != 0) begin
        e = q5.pop_front();
        chk("kind5", {31'd0, fe5}, {31'd0, e.err});
        chk("data5", {25'd0, dout5}, {24'd0, e.d});
        chk("lat5", cyc - e.t0, LAT5);
      end
    end
  end

  initial begin
    int cnt, c0, c1, gap;
    logic [7:0] d;
    logic ok;

    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 0);
    chk("rst_dv", {31'd0, dv}, 0);
    chk("rst_fe", {31'd0, fe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_dout5", {25'd0, dout5}, 0);
    chk("rst_busy5", {31'd0, busy5}, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame
    c0 = vld_cnt16;
    send_frame(0, 8'hA5, 1'b1);
    idle(0, 20);
    chk("a5_dout", {24'd0, dout}, 32'hA5);
    chk("a5_nvld", vld_cnt16 - c0, 1);
    chk("a5_busy", {31'd0, busy}, 0);

    // Glitch shorter than half a bit
    cnt = 0;
    c0  = vld_cnt16;
    c1  = fe_cnt16;
    for (int i = 0; i < 40; i++) begin
      rx = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("glitch_busy_len", {31'd0, (cnt >= 8) && (cnt <= 10)}, 1);
    chk("glitch_nstrobe", (vld_cnt16 - c0) + (fe_cnt16 - c1), 0);
    chk("glitch_dout", {24'd0, dout}, 32'hA5);

    // Framing error, then line held low
    c0 = vld_cnt16;
    c1 = fe_cnt16;
    send_frame(0, 8'h3C, 1'b0);
    cnt = 0;
    repeat (3 * CPP) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("ferr_quiet", cnt, 0);
    chk("ferr_nfe", fe_cnt16 - c1, 1);
    chk("ferr_nvld", vld_cnt16 - c0, 0);
    chk("ferr_dout", {24'd0, dout}, 32'hA5);
    idle(0, 10);

    // Back-to-back frames
    c0 = vld_cnt16;
    send_frame(0, 8'h00, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    idle(0, 20);
    chk("b2b_nvld", vld_cnt16 - c0, 2);
    chk("b2b_spacing", vld_last - vld_prev, 10 * CPP);
    chk("b2b_dout", {24'd0, dout}, 32'hFF);

    // Reset during data bit 3 of 0x81
    d  = 8'h81;
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (CPP) @(negedge clk);
    end
    rx = d[3];
    repeat (CPP / 2) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dout", {24'd0, dout}, 0);
    chk("mid_rst_dv", {31'd0, dv}, 0);
    chk("mid_rst_fe", {31'd0, fe}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    rx     = 1'b1;
    last16 = 8'h00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    c0 = vld_cnt16;
    send_frame(0, 8'h5A, 1'b1);
    idle(0, 20);
    chk("post_rst_dout", {24'd0, dout}, 32'h5A);
    chk("post_rst_nvld", vld_cnt16 - c0, 1);

    // Odd bit period, 7-bit words
    c0 = vld_cnt5;
    send_frame(1, 8'h55, 1'b1);
    idle(1, 10);
    chk("p5_dout", {25'd0, dout5}, 32'h55);
    chk("p5_nvld", vld_cnt5 - c0, 1);

    // Randomised traffic, occasional bad stop bits and zero-gap frames
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      gap = $urandom_range(0, 12);
      send_frame(0, d, ok);
      if (!ok) gap = gap + 2;
      if (gap > 0) idle(0, gap);
    end
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 6);
      send_frame(1, d, ok);
      if (!ok) gap = gap + 2;
      if (gap > 0) idle(1, gap);
    end

    idle(0, 30);
    idle(1, 30);
    chk("q16_drained", q16.size(), 0);
    chk("q5_drained", q5.size(), 0);
    chk("end_busy", {31'd0, busy | busy5}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the team's uart_tx transmitter: consumes the 1-bit line that uart_tx drives and recovers parallel words.
- Frame format matches uart_tx: one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1). Each bit lasts CLOCKS_PER_PULSE clk cycles.
- Synchronises the asynchronous line, validates the start bit at mid-bit, and samples each subsequent bit at mid-bit.
- Outputs a one-cycle valid strobe with the word, or a one-cycle framing-error strobe.

Parameters:
- CLOCKS_PER_PULSE, 16, clk cycles per serial bit; must be >= 4.
- DATA_WIDTH, 8, data bits per frame; must be >= 2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rx  in  1  serial line, asynchronous to clk, idles high
- data_out  out  DATA_WIDTH  last correctly framed word; holds until the next valid frame
- data_valid  out  1  one-cycle pulse; data_out was updated on this cycle
- frame_err  out  1  one-cycle pulse; the stop bit was sampled as 0
- rx_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - data_out = 0, data_valid = 0, frame_err = 0, rx_busy = 0.
  - Both synchroniser flops = 1, previous-sample flop = 1, state = IDLE, counters = 0.
  - Reset is asynchronous and may occur mid-frame; the partial frame is discarded.
- Input conditioning:
  - rx passes through a 2-flop synchroniser to produce rx_s.
  - rx_q is rx_s delayed by one cycle.
  - A falling edge is rx_q == 1 and rx_s == 0.
- Counters:
  - c_clocks, width $clog2(CLOCKS_PER_PULSE).
  - c_bits, width $clog2(DATA_WIDTH).
  - Shift register data, DATA_WIDTH bits.
- States (2-bit encoding): IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge: go to START, c_clocks = 0, c_bits = 0.
  - A line held low does not retrigger; only an edge does.
- START:
  - Count c_clocks up to CLOCKS_PER_PULSE/2 - 1 (integer division); at that point sample rx_s.
  - rx_s == 0: go to DATA, c_clocks = 0.
  - rx_s == 1: glitch; return to IDLE with no strobe.
- DATA:
  - At c_clocks == CLOCKS_PER_PULSE - 1: write data[c_bits] = rx_s and set c_clocks = 0.
  - If c_bits == DATA_WIDTH - 1, go to STOP; otherwise increment c_bits.
  - All other cycles increment c_clocks.
- STOP:
  - At c_clocks == CLOCKS_PER_PULSE - 1: sample rx_s and go to IDLE.
  - rx_s == 1: data_out = data and data_valid = 1, both on the same edge.
  - rx_s == 0: frame_err = 1; data_out unchanged.
- Strobes are registered and cleared on the following cycle; data_valid and frame_err are never high together.
- Latency: the sample point of data bit k lands CLOCKS_PER_PULSE/2 + (k+1)*CLOCKS_PER_PULSE cycles after the edge-detect cycle, to within ±1. data_valid rises one cycle after the stop-bit sample edge.
- Framing error followed by a line held low: the block stays in IDLE until rx rises and falls again.
- Back-to-back frames: a start edge arriving in the cycle the block returns to IDLE is detected. The stop sample occurs mid-stop-bit, so there is always at least CLOCKS_PER_PULSE/2 of margin.
- Unreachable state encodings return to IDLE.

Decomposition:
- Shared package uart_pkg:
  - State encodings (IDLE=2'b00, START=2'b01, DATA=2'b11, STOP=2'b10).
  - Default CLOCKS_PER_PULSE and DATA_WIDTH.
  - Used by both uart_tx and uart_rx.
- One sub-module, sync_2ff: 2-flop synchroniser with reset value parameter set to 1. It is reusable for other async inputs.
- The FSM and counters stay in uart_rx.

Test Plan:
- Loopback, uart_tx.tx -> uart_rx.rx, CLOCKS_PER_PULSE=16, DATA_WIDTH=8, send 0xA5:
  - data_out = 0xA5 with exactly one data_valid pulse.
  - frame_err stays 0; rx_busy returns to 0.
- Glitch: rx low for 4 clocks, then high:
  - Block returns to IDLE from START with no strobes.
  - rx_busy is high for about 8-10 cycles; data_out is unchanged.
- Framing error: drive the frame for 0x3C with the stop bit forced to 0, then hold the line low for 3 bit periods:
  - One frame_err pulse, no data_valid, data_out keeps its previous value.
  - No further activity until rx rises and falls again.
- Back-to-back: send 0x00 then 0xFF with no idle gap between frames:
  - Two data_valid pulses, carrying 0x00 then 0xFF, spaced by 10*16 cycles (±1).
- Reset mid-frame: assert rstn during data bit 3 of 0x81:
  - All outputs return to reset values immediately.
  - After release, a new frame 0x5A is received correctly and the partial frame produces no strobe.
- Parameter sweep, CLOCKS_PER_PULSE=5 (odd), DATA_WIDTH=7, send 7'h55 via loopback:
  - data_out = 7'h55, data_valid pulses once.
